three_bit_comparator: RTL and testbench
=======================================

THREE_BIT_COMPARATOR -- requirements
Module: three_bit_comparator

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits; supported range 1..8.

Ports:
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have in_valid  input  1  qualifies a and b for capture.
REQ-005 SHALL have a  input  WIDTH  unsigned operand A.
REQ-006 SHALL have b  input  WIDTH  unsigned operand B.
REQ-007 SHALL have out_valid  output  1  result registers hold a fresh result.
REQ-008 SHALL have sum  output  WIDTH  (a+b) modulo 2^WIDTH.
REQ-009 SHALL have cout  output  1  carry out of the MSB of a+b.
REQ-010 SHALL have a_less_b  output  1  1 when a < b.
REQ-011 SHALL have a_equal_b  output  1  1 when a == b.
REQ-012 SHALL have a_greater_b  output  1  1 when a > b.

Function
REQ-013 The adder SHALL be a ripple chain: bit 0 a half adder (s = a^b, carry = a&b), bits 1..WIDTH-1 full adders (sum = a^b^cin, cout = a&b | cin&(a^b)).
REQ-014 The half adder and full adder SHALL be separate submodules halfAdder(a, b, s, carry) and fullAdder(a, b, cin, sum, cout) instantiated by the top.
REQ-015 The compare SHALL be unsigned, MSB-first: the first differing bit from MSB decides lt/gt; no differing bit gives eq.
REQ-016 Exactly one of a_less_b, a_equal_b, a_greater_b SHALL be 1 whenever out_valid is 1.
REQ-017 Latency SHALL be 1 cycle: on a rising clk edge with in_valid=1, all result outputs load results of the a/b present at that edge and out_valid becomes 1.
REQ-018 On a rising clk edge with in_valid=0, out_valid SHALL become 0 and sum, cout and the compare flags SHALL hold their previous values.
REQ-019 Back-to-back in_valid=1 SHALL yield one result per cycle; there is no backpressure and no stall.
REQ-020 Overflow SHALL wrap: sum = (a+b) mod 2^WIDTH and cout = 1 when a+b >= 2^WIDTH.
REQ-021 Result outputs SHALL be driven only from registers, with no combinational path from inputs to outputs.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for clk, force out_valid=0, sum=0, cout=0, a_less_b=0, a_equal_b=1, a_greater_b=0; the flags match the result for a=b=0.
REQ-023 While rst_n=0, in_valid SHALL be ignored; the first capture occurs on the first rising clk edge after rst_n deasserts.
REQ-024 Reset asserted mid-stream SHALL discard the pending result; no result captured before reset appears after it.

Verification
REQ-025 Reset: assert rst_n=0 between clock edges -> outputs go to reset values at once; out_valid=0, a_equal_b=1.
REQ-026 Compare: a=6,b=1 -> gt=1; a=2,b=3 -> lt=1; a=5,b=4 -> gt=1; a=3,b=3 -> eq=1; each result appears 1 cycle after capture with out_valid=1.
REQ-027 Add: 0+0 -> sum=0,cout=0; 3+4 -> sum=7,cout=0; 4+4 -> sum=0,cout=1; 7+7 -> sum=6,cout=1.
REQ-028 Exhaustive: all 64 (a,b) pairs at WIDTH=3 streamed back-to-back -> every cycle {cout,sum}=a+b and flags match an unsigned reference model.
REQ-029 Hold: in_valid=1 for one cycle, then 0 -> out_valid pulses for one cycle; outputs keep the last result.
REQ-030 Submodules: halfAdder and fullAdder each driven with all input combinations -> outputs match their truth tables.

Source files
------------

// File: rtl/three_bit_comparator.sv
// Registered ripple-carry adder plus unsigned MSB-first magnitude comparator.
// Results load on a valid capture and hold otherwise.

module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);
  assign s     = a ^ b;
  assign carry = a & b;
endmodule

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic prop;
  assign prop = a ^ b;
  assign sum  = prop ^ cin;
  assign cout = (a & b) | (cin & prop);
endmodule

module three_bit_comparator #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             a_less_b,
  output logic             a_equal_b,
  output logic             a_greater_b
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic             lt_c, eq_c, gt_c;

  logic             valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  // Ripple chain: bit 0 has no carry-in, so it uses a half adder.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_ha
      halfAdder u_ha (
        .a    (a[i]),
        .b    (b[i]),
        .s    (sum_c[i]),
        .carry(carry_c[i])
      );
    end else begin : g_fa
      fullAdder u_fa (
        .a   (a[i]),
        .b   (b[i]),
        .cin (carry_c[i-1]),
        .sum (sum_c[i]),
        .cout(carry_c[i])
      );
    end
  end

  // First differing bit from the MSB decides the ordering.
  always_comb begin
    lt_c = 1'b0;
    gt_c = 1'b0;
    eq_c = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (eq_c && (a[i] != b[i])) begin
        eq_c = 1'b0;
        gt_c = a[i];
        lt_c = b[i];
      end
    end
  end

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    lt_d   = lt_q;
    eq_d   = eq_q;
    gt_d   = gt_q;
    if (in_valid) begin
      sum_d  = sum_c;
      cout_d = carry_c[WIDTH-1];
      lt_d   = lt_c;
      eq_d   = eq_c;
      gt_d   = gt_c;
    end
  end

  // Reset flags describe the a == b == 0 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign out_valid   = valid_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign a_less_b    = lt_q;
  assign a_equal_b   = eq_q;
  assign a_greater_b = gt_q;

endmodule

// File: tb/tb_three_bit_comparator.sv
// Bench for three_bit_comparator: directed table, exhaustive stream, hold,
// reset corners, random traffic against an arithmetic model, submodule truth tables.

module tb_three_bit_comparator;

  localparam int WIDTH = 3;
  localparam int MODW  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout, a_less_b, a_equal_b, a_greater_b;

  logic ha_a = 1'b0, ha_b = 1'b0, ha_s, ha_c;
  logic fa_a = 1'b0, fa_b = 1'b0, fa_ci = 1'b0, fa_s, fa_co;

  int n_checks = 0;
  int n_fail   = 0;

  three_bit_comparator #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .sum        (sum),
    .cout       (cout),
    .a_less_b   (a_less_b),
    .a_equal_b  (a_equal_b),
    .a_greater_b(a_greater_b)
  );

  halfAdder u_ha (.a(ha_a), .b(ha_b), .s(ha_s), .carry(ha_c));
  fullAdder u_fa (.a(fa_a), .b(fa_b), .cin(fa_ci), .sum(fa_s), .cout(fa_co));

  always #5 clk = ~clk;

  typedef struct {
    int   va;
    int   vb;
    int   esum;
    logic ecout;
    logic elt;
    logic eeq;
    logic egt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input int es, input logic ec,
                           input logic el, input logic eq, input logic eg);
    logic [WIDTH-1:0] es_w;
    es_w = es[WIDTH-1:0];
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".sum"}, 32'(sum), 32'(es_w));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".lt"}, 32'(a_less_b), 32'(el));
    check({tag, ".eq"}, 32'(a_equal_b), 32'(eq));
    check({tag, ".gt"}, 32'(a_greater_b), 32'(eg));
  endtask

  // Model: plain integer arithmetic and comparison.
  task automatic model(input int ma, input int mb, output int s, output logic c,
                       output logic lt, output logic eq, output logic gt);
    int t;
    t  = ma + mb;
    s  = t % MODW;
    c  = (t >= MODW);
    lt = (ma < mb);
    eq = (ma == mb);
    gt = (ma > mb);
  endtask

  task automatic drive(input logic v, input int da, input int db);
    in_valid = v;
    a = da[WIDTH-1:0];
    b = db[WIDTH-1:0];
  endtask

  initial begin
    int   es;
    logic ec, el, eq, eg, ev;
    int   ra, rb;
    logic rv;

    vecs[0] = '{6, 1, 7, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2, 3, 5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{5, 4, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3, 3, 6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3, 4, 7, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{7, 7, 6, 1'b1, 1'b0, 1'b1, 1'b0};

    // Asynchronous reset, well away from any clock edge.
    #1 rst_n = 1'b0;
    #2 check_all("reset", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // in_valid is ignored while reset is held.
    drive(1'b1, 5, 2);
    @(posedge clk); #1;
    check_all("in_reset", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("first_capture", 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk) drive(1'b1, vecs[i].va, vecs[i].vb);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].esum, vecs[i].ecout,
                vecs[i].elt, vecs[i].eeq, vecs[i].egt);
    end

    // Exhaustive, back-to-back.
    for (int i = 0; i < MODW * MODW; i++) begin
      @(negedge clk) drive(1'b1, i / MODW, i % MODW);
      @(posedge clk); #1;
      model(i / MODW, i % MODW, es, ec, el, eq, eg);
      check_all($sformatf("exh_%0d_%0d", i / MODW, i % MODW), 1'b1, es, ec, el, eq, eg);
    end

    // Hold: one valid cycle then idle with different operands on the bus.
    @(negedge clk) drive(1'b1, 1, 6);
    @(posedge clk); #1;
    check_all("hold_load", 1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) drive(1'b0, 7, 3);
    @(posedge clk); #1;
    check_all("hold_1", 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("hold_2", 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic with a holding model.
    es = 7; ec = 1'b0; el = 1'b1; eq = 1'b0; eg = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ra = int'($urandom_range(MODW - 1, 0));
      rb = int'($urandom_range(MODW - 1, 0));
      rv = 1'($urandom_range(1, 0));
      @(negedge clk) drive(rv, ra, rb);
      @(posedge clk); #1;
      ev = rv;
      if (rv) model(ra, rb, es, ec, el, eq, eg);
      check_all($sformatf("rand%0d", i), ev, es, ec, el, eq, eg);
    end

    // Mid-stream reset discards the captured result.
    @(negedge clk) drive(1'b1, 6, 7);
    @(posedge clk); #1;
    check_all("pre_reset", 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_all("mid_reset", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk) begin
      rst_n = 1'b1;
      drive(1'b0, 6, 7);
    end
    @(posedge clk); #1;
    check_all("post_reset", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Submodule truth tables.
    for (int i = 0; i < 4; i++) begin
      ha_a = 1'(i >> 1);
      ha_b = 1'(i);
      #1;
      check($sformatf("ha_s_%0d", i), 32'(ha_s), 32'((i >> 1) + (i & 1)) & 32'h1);
      check($sformatf("ha_c_%0d", i), 32'(ha_c), 32'(((i >> 1) + (i & 1)) >> 1));
    end
    for (int i = 0; i < 8; i++) begin
      fa_a  = 1'(i >> 2);
      fa_b  = 1'(i >> 1);
      fa_ci = 1'(i);
      #1;
      es = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      check($sformatf("fa_s_%0d", i), 32'(fa_s), 32'(es & 1));
      check($sformatf("fa_c_%0d", i), 32'(fa_co), 32'(es >> 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
